chacha_wb_initiator: RTL

Wishbone classic initiator that drives the word-addressed ChaCha accelerator register file (4-bit word address, 32-bit data) from a simple command/data stream interface. It turns one command into a burst of 1–16 single-beat Wishbone cycles at incrementing addresses. It holds CYC across the burst, returns read data on a response stream, and aborts on a missing ACK. Typical uses are as a test harness master, or a DMA-style front end that loads key/nonce and drains keystream without CPU involvement.

---
 rtl/chacha_wb_pkg.sv | 24 ++
 rtl/chacha_wb_initiator_if.sv | 47 ++++
 rtl/wb_timeout_ctr.sv | 24 ++
 rtl/chacha_wb_initiator.sv | 131 +++++++++++++
 4 files changed

// File: rtl/chacha_wb_pkg.sv
// Shared definitions for the ChaCha Wishbone initiator family.
// Contents: initiator state encoding, the default word-address width and
// the word offsets of the ChaCha accelerator register file.
package chacha_wb_pkg;

  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_BUS,
    S_RDATA,
    S_FINISH
  } state_e;

  // Accelerator register map (word offsets). Multi-word fields are
  // contiguous, starting at the listed base.
  localparam logic [3:0] REG_KEY0   = 4'h0;  // key words 0..7
  localparam logic [3:0] REG_NONCE0 = 4'h8;  // nonce words 0..1
  localparam logic [3:0] REG_CNT0   = 4'hA;  // block counter words 0..1
  localparam logic [3:0] REG_CTRL   = 4'hC;  // control / status
  localparam logic [3:0] REG_OUT    = 4'hD;  // keystream output window

endpackage

// File: rtl/chacha_wb_initiator_if.sv
// Bundle of the initiator's command/data streams and its Wishbone bus.
// modport master: the initiator (drives ready/response streams and the bus).
// modport slave : the environment (drives commands, write data, responder).
interface chacha_wb_initiator_if #(
  parameter int ADDR_W = 4
) ();
  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [3:0]        cmd_len;
  // write-data stream
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_data;
  // read-data stream
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_data;
  logic              rd_last;
  // completion
  logic              done;
  logic              err;
  // Wishbone classic
  logic              wb_CYC;
  logic              wb_STB;
  logic              wb_WE;
  logic [ADDR_W-1:0] wb_ADR;
  logic [31:0]       wb_DAT_MOSI;
  logic [31:0]       wb_DAT_MISO;
  logic              wb_ACK;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_len, wr_valid, wr_data, rd_ready,
           wb_DAT_MISO, wb_ACK,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
           wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_len, wr_valid, wr_data, rd_ready,
           wb_DAT_MISO, wb_ACK,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
           wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI
  );
endinterface

// File: rtl/wb_timeout_ctr.sv
// Loadable up-counter with a terminal flag, used to bound Wishbone waits.
// Ports: clk, reset_n (async, active low); load_i clears the count;
// en_i increments; term_o is high in the cycle whose increment brings the
// count to LIMIT, i.e. in the LIMIT-th enabled cycle after a load.
module wb_timeout_ctr #(
  parameter int W     = 8,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic term_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (en_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign term_o = (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/chacha_wb_initiator.sv
// Wishbone classic initiator for the ChaCha accelerator register file.
// One command becomes 1..16 single-beat cycles at incrementing (wrapping)
// word addresses with CYC held across the burst; reads are returned on a
// response stream and a beat with no ACK within TIMEOUT cycles aborts.
// Ports: clk, reset_n (async, active low); bus (master modport) carries
// the cmd / wr / rd streams, done/err, and the Wishbone signals.
module chacha_wb_initiator
  import chacha_wb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset_n,
  chacha_wb_initiator_if.master bus
);
  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [3:0]        beat_q, beat_d;     // beats remaining after the current one
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       mosi_q, mosi_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              err_q, err_d;
  logic              to_term;

  // Counter sits at zero outside BUS, so every strobe phase starts fresh.
  wb_timeout_ctr #(.W(8), .LIMIT(TIMEOUT)) u_to (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (state_q != S_BUS),
    .en_i   (state_q == S_BUS),
    .term_o (to_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      beat_q  <= '0;
      adr_q   <= '0;
      mosi_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      adr_q   <= adr_d;
      mosi_q  <= mosi_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    beat_d  = beat_q;
    adr_d   = adr_q;
    mosi_d  = mosi_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        we_d    = bus.cmd_we;
        adr_d   = bus.cmd_adr;
        beat_d  = bus.cmd_len;
        err_d   = 1'b0;
        state_d = bus.cmd_we ? S_WDATA : S_BUS;
      end
      S_WDATA: if (bus.wr_valid) begin
        mosi_d  = bus.wr_data;
        state_d = S_BUS;
      end
      S_BUS: begin
        // ACK wins over a timeout landing in the same cycle.
        if (bus.wb_ACK) begin
          adr_d = adr_q + 1'b1;
          if (!we_q) begin
            rdat_d  = bus.wb_DAT_MISO;
            state_d = S_RDATA;
          end else if (beat_q == '0) begin
            state_d = S_FINISH;
          end else begin
            beat_d  = beat_q - 1'b1;
            state_d = S_WDATA;
          end
        end else if (to_term) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      // Read beats count down on the response handshake so rd_last can
      // look at the counter while the word is being offered.
      S_RDATA: if (bus.rd_ready) begin
        if (beat_q == '0) begin
          state_d = S_FINISH;
        end else begin
          beat_d  = beat_q - 1'b1;
          state_d = S_BUS;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_last   = 1'b0;
    bus.done      = 1'b0;
    bus.wb_CYC    = 1'b0;
    bus.wb_STB    = 1'b0;
    bus.wb_WE     = 1'b0;
    unique case (state_q)
      S_IDLE:   bus.cmd_ready = 1'b1;
      S_WDATA:  begin bus.wr_ready = 1'b1; bus.wb_CYC = 1'b1; end
      S_BUS:    begin bus.wb_CYC = 1'b1; bus.wb_STB = 1'b1; bus.wb_WE = we_q; end
      S_RDATA:  begin bus.wb_CYC = 1'b1; bus.rd_valid = 1'b1; bus.rd_last = (beat_q == '0); end
      S_FINISH: bus.done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.rd_data     = rdat_q;
  assign bus.wb_ADR      = adr_q;
  assign bus.wb_DAT_MOSI = mosi_q;
  assign bus.err         = err_q;
endmodule
